// File: rtl/note_judge.sv
// Rhythm-game note judge: tracks armed note windows per key, grades key presses
// against them, and keeps a running combo and score from the judgement stream.
module note_judge #(
    parameter int NUM_KEYS = 61,
    parameter int KEY_W    = 6,
    parameter int WINDOW   = 8,
    parameter int PERFECT  = 3,
    parameter int SCORE_W  = 18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               key_trigger,
    input  logic [KEY_W:0]     key_data,
    input  logic               note_trigger,
    input  logic [KEY_W-1:0]   note_key,
    output logic [NUM_KEYS-1:0] pressed,
    output logic               evt_valid,
    output logic [1:0]         evt_code,
    output logic [KEY_W-1:0]   evt_key,
    output logic [7:0]         combo,
    output logic [SCORE_W-1:0] score
);

    localparam logic [KEY_W:0] KEY_LIMIT = (KEY_W+1)'(NUM_KEYS);
    localparam logic [3:0]     WIN_LOAD  = 4'(WINDOW);
    localparam logic [3:0]     PERF_TH   = 4'(WINDOW - PERFECT);

    localparam logic [1:0] CODE_PERFECT = 2'd0;
    localparam logic [1:0] CODE_GOOD    = 2'd1;
    localparam logic [1:0] CODE_MISS    = 2'd2;
    localparam logic [1:0] CODE_WRONG   = 2'd3;

    function automatic logic [3:0] hit_points(input logic [1:0] code, input logic [7:0] c);
        logic [2:0] mult;
        logic [3:0] base;
        mult = (c[7:3] > 5'd3) ? 3'd4 : 3'd1 + {1'b0, c[4:3]};
        base = (code == CODE_PERFECT) ? 4'd3 : 4'd1;
        return base * {1'b0, mult};
    endfunction

    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s,
                                                     input logic [3:0] pts);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + (SCORE_W+1)'(pts);
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [7:0] sat_combo(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic [3:0]          cnt      [NUM_KEYS];
    logic [3:0]          cnt_nxt  [NUM_KEYS];
    logic [NUM_KEYS-1:0] miss_pend;
    logic [NUM_KEYS-1:0] miss_nxt;
    logic [NUM_KEYS-1:0] pressed_nxt;

    logic [KEY_W-1:0]    key_idx;
    logic                key_press;
    logic                key_ok;
    logic                note_ok;

    logic                hit_vld;
    logic [1:0]          hit_code;
    logic                miss_any;
    logic [KEY_W-1:0]    miss_key;

    logic                vld_p0;
    logic [1:0]          code_p0;
    logic [KEY_W-1:0]    key_p0;
    logic [7:0]          combo_nxt;
    logic [SCORE_W-1:0]  score_nxt;

    assign key_idx   = key_data[KEY_W-1:0];
    assign key_press = key_data[KEY_W];
    assign key_ok    = key_trigger  && ({1'b0, key_idx}  < KEY_LIMIT);
    assign note_ok   = note_trigger && ({1'b0, note_key} < KEY_LIMIT);

    // Stage p0: window bookkeeping, event arbitration and scoring
    always_comb begin
        cnt_nxt     = cnt;
        miss_nxt    = miss_pend;
        pressed_nxt = pressed;
        hit_vld     = 1'b0;
        hit_code    = CODE_WRONG;

        if (key_ok) begin
            if (key_press) begin
                pressed_nxt[key_idx] = 1'b1;
                hit_vld              = 1'b1;
                if (cnt[key_idx] != 4'd0) begin
                    hit_code         = (cnt[key_idx] > PERF_TH) ? CODE_PERFECT : CODE_GOOD;
                    cnt_nxt[key_idx] = 4'd0;
                end
            end else begin
                pressed_nxt[key_idx] = 1'b0;
            end
        end

        if (tick) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (cnt[i] != 4'd0 && !(hit_vld && key_idx == KEY_W'(i))) begin
                    cnt_nxt[i] = cnt[i] - 4'd1;
                    if (cnt[i] == 4'd1) miss_nxt[i] = 1'b1;
                end
            end
        end

        // A press consumed in this same cycle leaves the key unarmed before the re-arm.
        if (note_ok) begin
            if (cnt[note_key] != 4'd0 && !(hit_vld && key_idx == note_key))
                miss_nxt[note_key] = 1'b1;
            cnt_nxt[note_key] = WIN_LOAD;
        end

        miss_any = 1'b0;
        miss_key = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (miss_nxt[i]) begin
                miss_any = 1'b1;
                miss_key = KEY_W'(i);
            end
        end

        vld_p0  = hit_vld | miss_any;
        code_p0 = hit_vld ? hit_code : CODE_MISS;
        key_p0  = hit_vld ? key_idx  : miss_key;
        if (!hit_vld && miss_any) miss_nxt[miss_key] = 1'b0;

        combo_nxt = combo;
        score_nxt = score;
        if (vld_p0) begin
            if (code_p0 == CODE_PERFECT || code_p0 == CODE_GOOD) begin
                score_nxt = sat_score(score, hit_points(code_p0, combo));
                combo_nxt = sat_combo(combo);
            end else begin
                combo_nxt = 8'd0;
            end
        end
    end

    // Stage p1: registered state and event outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '{default: '0};
            miss_pend <= '0;
            pressed   <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            evt_key   <= '0;
            combo     <= '0;
            score     <= '0;
        end else begin
            cnt       <= cnt_nxt;
            miss_pend <= miss_nxt;
            pressed   <= pressed_nxt;
            evt_valid <= vld_p0;
            evt_code  <= code_p0;
            evt_key   <= key_p0;
            combo     <= combo_nxt;
            score     <= score_nxt;
        end
    end

endmodule

// File: tb/tb_note_judge.sv
// Scoreboard bench for note_judge: a tick-deadline reference model predicts
// every judgement; a monitor checks each event the DUTs present.
module tb_note_judge;
    localparam int NK = 61, KW = 6, WIN = 8, PERF = 3, SW = 18, SWS = 6;

    logic          clk = 1'b0, reset = 1'b0;
    logic          tick = 1'b0, key_trigger = 1'b0, note_trigger = 1'b0;
    logic [KW:0]   key_data = '0;
    logic [KW-1:0] note_key = '0;

    logic [NK-1:0] pressed, s_pressed;
    logic          evt_valid, s_evt_valid;
    logic [1:0]    evt_code, s_evt_code;
    logic [KW-1:0] evt_key, s_evt_key;
    logic [7:0]    combo, s_combo;
    logic [SW-1:0] score;
    logic [SWS-1:0] s_score;

    note_judge u_dut (
        .clk(clk), .reset(reset), .tick(tick), .key_trigger(key_trigger),
        .key_data(key_data), .note_trigger(note_trigger), .note_key(note_key),
        .pressed(pressed), .evt_valid(evt_valid), .evt_code(evt_code),
        .evt_key(evt_key), .combo(combo), .score(score));

    note_judge #(.SCORE_W(SWS)) u_small (
        .clk(clk), .reset(reset), .tick(tick), .key_trigger(key_trigger),
        .key_data(key_data), .note_trigger(note_trigger), .note_key(note_key),
        .pressed(s_pressed), .evt_valid(s_evt_valid), .evt_code(s_evt_code),
        .evt_key(s_evt_key), .combo(s_combo), .score(s_score));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc; int code; int key; int combo; int score; int score_s;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference model: an armed note expires when the global tick count reaches its deadline.
    bit            m_armed[NK];
    int            m_dead[NK];
    bit            m_mp[NK];
    logic [NK-1:0] m_pressed;
    int            m_ticks, m_combo, m_score, m_score_s;

    function automatic void model_reset();
        for (int k = 0; k < NK; k++) begin
            m_armed[k] = 0; m_dead[k] = 0; m_mp[k] = 0;
        end
        m_pressed = '0;
        m_ticks = 0; m_combo = 0; m_score = 0; m_score_s = 0;
    endfunction

    task automatic drive(input bit t, input bit kt, input bit kp, input int kk,
                         input bit nt, input int nk);
        int code, ekey, c, mult, pts;
        @(negedge clk);
        tick         = t;
        key_trigger  = kt;
        key_data     = {kp, kk[KW-1:0]};
        note_trigger = nt;
        note_key     = nk[KW-1:0];
        code = -1; ekey = 0;
        if (kt && kk < NK) begin
            if (kp) begin
                m_pressed[kk] = 1'b1;
                if (m_armed[kk]) begin
                    c = m_dead[kk] - m_ticks;
                    code = (c > WIN - PERF) ? 0 : 1;
                    m_armed[kk] = 0;
                end else begin
                    code = 3;
                end
                ekey = kk;
            end else begin
                m_pressed[kk] = 1'b0;
            end
        end
        if (t) begin
            m_ticks++;
            for (int k = 0; k < NK; k++)
                if (m_armed[k] && m_dead[k] == m_ticks) begin
                    m_armed[k] = 0; m_mp[k] = 1;
                end
        end
        if (nt && nk < NK) begin
            if (m_armed[nk]) m_mp[nk] = 1;
            m_armed[nk] = 1;
            m_dead[nk]  = m_ticks + WIN;
        end
        if (code < 0) begin
            for (int k = 0; k < NK; k++)
                if (m_mp[k]) begin
                    code = 2; ekey = k; m_mp[k] = 0;
                    break;
                end
        end
        if (code >= 0) begin
            if (code < 2) begin
                mult = 1 + (((m_combo / 8) > 3) ? 3 : (m_combo / 8));
                pts  = ((code == 0) ? 3 : 1) * mult;
                m_score   = (m_score + pts > (1 << SW) - 1) ? (1 << SW) - 1 : m_score + pts;
                m_score_s = (m_score_s + pts > (1 << SWS) - 1) ? (1 << SWS) - 1 : m_score_s + pts;
                m_combo   = (m_combo < 255) ? m_combo + 1 : 255;
            end else begin
                m_combo = 0;
            end
            q.push_back('{cyc + 1, code, ekey, m_combo, m_score, m_score_s});
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        tick = 0; key_trigger = 0; note_trigger = 0;
        #2 reset = 1'b0;
        #1;
        if (check) begin
            chk("rst_evt_valid", evt_valid, 0);
            chk("rst_evt_code", evt_code, 0);
            chk("rst_evt_key", evt_key, 0);
            chk("rst_combo", combo, 0);
            chk("rst_score", score, 0);
            chk("rst_pressed", pressed, 0);
            chk("rst_small_score", s_score, 0);
        end
        q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic chk_pressed(input string name);
        chk(name, pressed, m_pressed);
        chk({name, "_small"}, s_pressed, m_pressed);
    endtask

    // Monitor: pops one expectation per presented event, flags missing/unexpected ones.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (evt_valid) begin
                    if (q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_evt: got code %0d key %0d at cycle %0d, required no event",
                                 evt_code, evt_key, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("evt_cycle", cyc, e.cyc);
                        chk("evt_code", evt_code, e.code);
                        chk("evt_key", evt_key, e.key);
                        chk("evt_combo", combo, e.combo);
                        chk("evt_score", score, e.score);
                        chk("small_valid", s_evt_valid, 1);
                        chk("small_code", s_evt_code, e.code);
                        chk("small_key", s_evt_key, e.key);
                        chk("small_combo", s_combo, e.combo);
                        chk("small_score", s_score, e.score_s);
                    end
                end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                    e = q.pop_front();
                    n_checks++; n_fail++;
                    $display("FAIL missing_evt: got no event at cycle %0d, required code %0d key %0d",
                             cyc, e.code, e.key);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        do_reset(1);

        // single perfect hit
        drive(0, 0, 0, 0, 1, 5);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 5, 0, 0);
        idle();
        chk("hit5_score", score, 3);
        chk("hit5_combo", combo, 1);
        chk_pressed("hit5_pressed");

        // three notes expire together: misses in index order
        do_reset(0);
        drive(0, 0, 0, 0, 1, 9);
        drive(0, 0, 0, 0, 1, 2);
        drive(0, 0, 0, 0, 1, 7);
        repeat (8) drive(1, 0, 0, 0, 0, 0);
        repeat (4) idle();
        chk("miss3_score", score, 0);
        chk("miss3_combo", combo, 0);

        // combo multiplier kicks in on the 9th hit, then a wrong press
        do_reset(0);
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 0, 1, 10 + i);
            drive(1, 0, 0, 0, 0, 0);
            drive(0, 1, 1, 10 + i, 0, 0);
            drive(0, 1, 0, 10 + i, 0, 0);
        end
        idle();
        chk("mult_score", score, 30);
        chk("mult_combo", combo, 9);
        drive(0, 1, 1, 40, 0, 0);
        idle();
        chk("wrong_combo", combo, 0);
        chk("wrong_score", score, 30);

        // press and tick on the last window tick
        do_reset(0);
        drive(0, 0, 0, 0, 1, 20);
        repeat (7) drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 20, 0, 0);
        repeat (10) drive(1, 0, 0, 0, 0, 0);
        chk("edge_score", score, 1);
        chk("edge_combo", combo, 1);

        // score saturation on the narrow instance
        do_reset(0);
        repeat (30) begin
            drive(0, 0, 0, 0, 1, 30);
            drive(1, 0, 0, 0, 0, 0);
            drive(0, 1, 1, 30, 0, 0);
        end
        idle();
        chk("sat_small_score", s_score, 63);
        chk("sat_score", score, 216);
        chk("sat_combo", combo, 30);

        // same-cycle press and re-arm, then the re-armed note expires
        do_reset(0);
        drive(0, 0, 0, 0, 1, 33);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 33, 1, 33);
        repeat (9) drive(1, 0, 0, 0, 0, 0);
        repeat (2) idle();
        chk("rearm_combo", combo, 0);
        chk("rearm_score", score, 3);

        // randomized traffic including out-of-range keys
        do_reset(0);
        for (int n = 0; n < 2000; n++) begin
            bit t, kt, kp, nt;
            int kk, nk;
            t  = ($urandom_range(0, 3) == 0);
            kt = ($urandom_range(0, 2) == 0);
            kp = ($urandom_range(0, 9) < 7);
            kk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
            nt = ($urandom_range(0, 3) == 0);
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
            drive(t, kt, kp, kk, nt, nk);
            if (n % 100 == 99) begin
                idle();
                chk_pressed("rand_pressed");
            end
        end
        repeat (70) idle();

        // asynchronous reset mid-stream with armed keys and a held key
        do_reset(0);
        drive(0, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 3);
        drive(0, 0, 0, 0, 1, 4);
        drive(0, 0, 0, 0, 1, 5);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 3, 0, 0);
        do_reset(1);
        repeat (12) drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 63, 0, 0);
        drive(0, 1, 1, 61, 1, 62);
        idle();
        chk("post_rst_valid", evt_valid, 0);
        chk_pressed("post_rst_pressed");
        chk("post_rst_score", score, 0);

        repeat (3) idle();
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
